mem_io_responder: RTL and testbench

- Responder end of the byte-wide memory bus driven by the CPU memory controller.
- Each cycle it takes one byte access (rw, 32-bit address, write byte) and returns the read byte one cycle later.
- Decodes the address into a synchronous byte RAM or a small memory-mapped IO window at 0x30000.
- The IO window buffers a serial byte stream through TX and RX FIFOs.

---
 rtl/mem_io_responder.sv | 218 +++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the byte-wide CPU memory bus.
// Each access targets either a synchronous byte RAM or a small IO window at
// 0x30000. The IO window buffers a serial byte stream through TX/RX FIFOs.
// Read data comes back on ram_data_o one cycle after the address.

// Byte FIFO: circular buffer with wrap-around pointers and an occupancy count.
// The caller never pops when empty and never pushes when full unless it also
// pops in the same cycle.
module mem_io_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    // Entry storage, written at the tail on push.
    // NOTE: storage has no reset on purpose; the pointers and count define
    // which entries are live. State updates use non-blocking assignments so
    // every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign full  = (count == COUNT_FULL);
    // An empty FIFO presents 0 rather than a stale entry.
    assign head  = empty ? 8'h00 : mem[rd_ptr];

endmodule

module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ram_rw_i,
    input  logic [31:0] ram_addr_i,
    input  logic [7:0]  ram_data_i,
    output logic [7:0]  ram_data_o,
    output logic [7:0]  io_tx_data_o,
    output logic        io_tx_valid_o,
    input  logic        io_tx_ready_i,
    input  logic [7:0]  io_rx_data_i,
    input  logic        io_rx_valid_i,
    output logic        io_rx_ready_o
);

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    // Last bus-side access, used to suppress repeated IO side effects when the
    // controller re-presents the same IO access on its trailing OK cycle.
    typedef struct packed {
        logic       valid;
        logic       rw;
        logic [2:0] off;
    } io_access_t;

    typedef enum logic {
        SRC_RAM = 1'b0,
        SRC_IO  = 1'b1
    } rd_src_t;

    logic [7:0]                ram [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [7:0]                ram_q;
    logic [7:0]                io_q;
    logic [7:0]                io_rd_byte;
    rd_src_t                   rd_src;
    io_access_t                last_io;

    logic       io_sel;
    logic [2:0] io_off;
    logic       bus_act;
    logic       io_exec;

    logic       tx_push;
    logic       tx_pop;
    logic       tx_empty;
    logic       tx_full;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_empty;
    logic       rx_full;
    logic [7:0] rx_head;

    // Address bits above the decode are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ram_addr_i[31:18];

    assign io_sel  = (ram_addr_i[17:16] == 2'b11);
    assign io_off  = ram_addr_i[2:0];
    assign ram_idx = ram_addr_i[RAM_ADDR_WIDTH-1:0];
    // A reset cycle cancels whatever access is on the bus.
    assign bus_act = rdy && !rst;

    // A side effect runs unless this is a repeat of the previous IO access.
    assign io_exec = !last_io.valid || (last_io.rw != ram_rw_i) || (last_io.off != io_off);

    assign tx_pop  = !tx_empty && io_tx_ready_i;
    assign tx_push = bus_act && io_sel && ram_rw_i && (io_off == OFF_DATA) && io_exec
                     && (!tx_full || tx_pop);

    assign rx_pop  = bus_act && io_sel && !ram_rw_i && (io_off == OFF_DATA) && io_exec
                     && !rx_empty;
    // A full RX FIFO still accepts a byte in the cycle the bus pops one.
    assign io_rx_ready_o = !rx_full || rx_pop;
    assign rx_push       = io_rx_valid_i && io_rx_ready_o;

    assign io_tx_valid_o = !tx_empty;

    mem_io_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (ram_data_i),
        .pop       (tx_pop),
        .head      (io_tx_data_o),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    mem_io_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (io_rx_data_i),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    // IO read byte for the current offset (data head or status).
    always_comb begin
        // NOTE: default first so every path assigns the byte and no latch forms.
        io_rd_byte = 8'h00;
        case (io_off)
            OFF_DATA:   io_rd_byte = rx_head;
            OFF_STATUS: io_rd_byte = {6'b0, tx_full, !rx_empty};
            default:    io_rd_byte = 8'h00;
        endcase
    end

    // Single-port RAM: write, or registered read with one-cycle latency.
    always_ff @(posedge clk) begin
        if (bus_act && !io_sel) begin
            if (ram_rw_i) begin
                ram[ram_idx] <= ram_data_i;
            end else begin
                ram_q <= ram[ram_idx];
            end
        end
    end

    // Bus-side bookkeeping: last IO access, read source and captured IO byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_io <= '0;
            rd_src  <= SRC_IO;
            io_q    <= 8'h00;
        end else if (rdy) begin
            last_io.valid <= io_sel;
            last_io.rw    <= ram_rw_i;
            last_io.off   <= io_off;
            if (!ram_rw_i) begin
                rd_src <= io_sel ? SRC_IO : SRC_RAM;
                // A suppressed read keeps the byte from the executed one.
                if (io_sel && io_exec) begin
                    io_q <= io_rd_byte;
                end
            end
        end
    end

    // Reset selects the IO byte, which resets to 0, so no RAM reset is needed.
    assign ram_data_o = (rd_src == SRC_IO) ? io_q : ram_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// queue/array model of the bus, RAM and IO window.

module tb_mem_io_responder;

    localparam int FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ram_rw_i;
    logic [31:0] ram_addr_i;
    logic [7:0]  ram_data_i;
    logic [7:0]  ram_data_o;
    logic [7:0]  io_tx_data_o;
    logic        io_tx_valid_o;
    logic        io_tx_ready_i;
    logic [7:0]  io_rx_data_i;
    logic        io_rx_valid_i;
    logic        io_rx_ready_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    mem_io_responder dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .ram_rw_i      (ram_rw_i),
        .ram_addr_i    (ram_addr_i),
        .ram_data_i    (ram_data_i),
        .ram_data_o    (ram_data_o),
        .io_tx_data_o  (io_tx_data_o),
        .io_tx_valid_o (io_tx_valid_o),
        .io_tx_ready_i (io_tx_ready_i),
        .io_rx_data_i  (io_rx_data_i),
        .io_rx_valid_i (io_rx_valid_i),
        .io_rx_ready_o (io_rx_ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [int];
    logic [7:0] m_tx [$];
    logic [7:0] m_rx [$];
    bit         m_last_v   = 1'b0;
    bit         m_last_rw  = 1'b0;
    logic [2:0] m_last_off = 3'd0;
    logic [7:0] m_io_hold  = 8'h00;
    logic [7:0] m_exp_data = 8'h00;

    function automatic bit m_is_io();
        return ram_addr_i[17:16] == 2'b11;
    endfunction

    function automatic bit m_exec();
        return !m_last_v || (m_last_rw != ram_rw_i) || (m_last_off != ram_addr_i[2:0]);
    endfunction

    function automatic bit m_bus_rx_pop();
        return !rst && rdy && m_is_io() && !ram_rw_i && (ram_addr_i[2:0] == 3'd0)
               && m_exec() && (m_rx.size() > 0);
    endfunction

    always @(posedge clk) begin : model
        bit         tx_pop, rx_pop, tx_push, rx_push, io, ex;
        logic [2:0] off;
        logic [7:0] b;
        int         idx;
        if (rst) begin
            m_tx.delete();
            m_rx.delete();
            m_last_v   = 1'b0;
            m_io_hold  = 8'h00;
            m_exp_data = 8'h00;
        end else begin
            io      = m_is_io();
            off     = ram_addr_i[2:0];
            ex      = m_exec();
            tx_pop  = (m_tx.size() > 0) && io_tx_ready_i;
            rx_pop  = m_bus_rx_pop();
            tx_push = 1'b0;
            rx_push = io_rx_valid_i && ((m_rx.size() < FIFO_DEPTH) || rx_pop);
            if (rdy) begin
                if (!io) begin
                    idx = int'(ram_addr_i[16:0]);
                    if (ram_rw_i) m_mem[idx] = ram_data_i;
                    else m_exp_data = m_mem.exists(idx) ? m_mem[idx] : 8'hxx;
                end else if (ram_rw_i) begin
                    tx_push = (off == 3'd0) && ex && ((m_tx.size() < FIFO_DEPTH) || tx_pop);
                end else begin
                    if (ex) begin
                        if (off == 3'd0)      b = (m_rx.size() > 0) ? m_rx[0] : 8'h00;
                        else if (off == 3'd4) b = {6'b0, m_tx.size() == FIFO_DEPTH, m_rx.size() > 0};
                        else                  b = 8'h00;
                        m_io_hold = b;
                    end
                    m_exp_data = m_io_hold;
                end
                m_last_v   = io;
                m_last_rw  = ram_rw_i;
                m_last_off = off;
            end
            if (tx_pop)  void'(m_tx.pop_front());
            if (tx_push) m_tx.push_back(ram_data_i);
            if (rx_pop)  void'(m_rx.pop_front());
            if (rx_push) m_rx.push_back(io_rx_data_i);
        end
    end

    // Compare process: every cycle, mid-period, against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_ram_data_o", ram_data_o, m_exp_data);
            check("cmp_tx_valid", {7'b0, io_tx_valid_o}, {7'b0, m_tx.size() != 0});
            check("cmp_tx_data", io_tx_data_o, (m_tx.size() != 0) ? m_tx[0] : 8'h00);
            check("cmp_rx_ready", {7'b0, io_rx_ready_o},
                  {7'b0, (m_rx.size() < FIFO_DEPTH) || m_bus_rx_pop()});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_set(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
        rdy        = r;
        ram_rw_i   = w;
        ram_addr_i = a;
        ram_data_i = d;
    endtask

    task automatic bus_op(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
        bus_set(r, w, a, d);
        tick();
    endtask

    // RAM read of a pre-written index: re-arms IO side effects.
    task automatic idle();
        bus_op(1'b1, 1'b0, 32'h0, 8'h00);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  d;
        int          k;
        rst = 1'b1;
        bus_set(1'b0, 1'b0, 32'h0, 8'h00);
        io_tx_ready_i = 1'b0;
        io_rx_valid_i = 1'b0;
        io_rx_data_i  = 8'h00;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_ram_data_o", ram_data_o, 8'h00);
        check("rst_tx_valid", {7'b0, io_tx_valid_o}, 8'h00);
        check("rst_tx_data", io_tx_data_o, 8'h00);
        check("rst_rx_ready", {7'b0, io_rx_ready_o}, 8'h01);
        rst = 1'b0;

        // Pre-write the RAM index pool used by all later reads.
        for (int i = 0; i < 32; i++) begin
            bus_op(1'b1, 1'b1, 32'(i), 8'(i) ^ 8'h3C);
            bus_op(1'b1, 1'b1, 32'h10000 | 32'(i), 8'(i) ^ 8'hC3);
        end

        // RAM write/read, latency and bit-16 aliasing.
        bus_op(1'b1, 1'b1, 32'h00010, 8'hA5);
        check("ram_before_read", ram_data_o, 8'h00);
        bus_op(1'b1, 1'b0, 32'h00010, 8'h00);
        check("ram_rd_a5", ram_data_o, 8'hA5);
        bus_op(1'b1, 1'b1, 32'h10010, 8'h5A);
        bus_op(1'b1, 1'b0, 32'h00010, 8'h00);
        check("ram_alias_low", ram_data_o, 8'hA5);
        bus_op(1'b1, 1'b0, 32'h10010, 8'h00);
        check("ram_alias_high", ram_data_o, 8'h5A);
        bus_op(1'b1, 1'b0, 32'hFFFC0010, 8'h00);
        check("ram_upper_ignored", ram_data_o, 8'hA5);

        // TX write held for S0 + OK: exactly one push.
        bus_op(1'b1, 1'b1, 32'h30000, 8'h48);
        bus_op(1'b1, 1'b1, 32'h30000, 8'h48);
        idle();
        check("tx_one_valid", {7'b0, io_tx_valid_o}, 8'h01);
        check("tx_one_data", io_tx_data_o, 8'h48);
        io_tx_ready_i = 1'b1;
        tick();
        io_tx_ready_i = 1'b0;
        check("tx_one_popped", {7'b0, io_tx_valid_o}, 8'h00);

        // RX injection and bus reads.
        io_rx_valid_i = 1'b1;
        io_rx_data_i  = 8'h41;
        idle();
        io_rx_data_i  = 8'h42;
        idle();
        io_rx_valid_i = 1'b0;
        bus_op(1'b1, 1'b0, 32'h30004, 8'h00);
        check("status_rx_nonempty", ram_data_o, 8'h01);
        idle();
        bus_op(1'b1, 1'b0, 32'h30000, 8'h00);
        check("rx_read_41", ram_data_o, 8'h41);
        idle();
        bus_op(1'b1, 1'b0, 32'h30000, 8'h00);
        check("rx_read_42", ram_data_o, 8'h42);
        idle();
        bus_op(1'b1, 1'b0, 32'h30000, 8'h00);
        check("rx_read_empty", ram_data_o, 8'h00);
        bus_op(1'b1, 1'b0, 32'h30004, 8'h00);
        check("status_empty", ram_data_o, 8'h00);
        // Back-to-back repeated read: one pop, same byte twice.
        io_rx_valid_i = 1'b1;
        io_rx_data_i  = 8'h43;
        idle();
        io_rx_data_i  = 8'h44;
        idle();
        io_rx_valid_i = 1'b0;
        bus_op(1'b1, 1'b0, 32'h30000, 8'h00);
        check("rx_repeat_first", ram_data_o, 8'h43);
        bus_op(1'b1, 1'b0, 32'h30000, 8'h00);
        check("rx_repeat_held", ram_data_o, 8'h43);
        idle();
        bus_op(1'b1, 1'b0, 32'h30000, 8'h00);
        check("rx_repeat_next", ram_data_o, 8'h44);

        // TX fill with 17 writes; the 17th is dropped.
        for (int i = 0; i < 17; i++) begin
            bus_op(1'b1, 1'b1, 32'h30000, 8'(i));
            idle();
        end
        bus_op(1'b1, 1'b0, 32'h30004, 8'h00);
        check("status_tx_full", ram_data_o, 8'h02);
        rdy = 1'b0;
        io_tx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("tx_drain_data", io_tx_data_o, 8'(i));
            tick();
        end
        io_tx_ready_i = 1'b0;
        check("tx_drained", {7'b0, io_tx_valid_o}, 8'h00);
        bus_op(1'b1, 1'b1, 32'h30000, 8'h77);
        check("tx_wrap_data", io_tx_data_o, 8'h77);
        io_tx_ready_i = 1'b1;
        bus_op(1'b0, 1'b0, 32'h0, 8'h00);
        io_tx_ready_i = 1'b0;

        // RX full, then simultaneous external push and bus pop.
        io_rx_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            io_rx_data_i = 8'h80 + 8'(i);
            tick();
        end
        io_rx_valid_i = 1'b0;
        check("rx_full_not_ready", {7'b0, io_rx_ready_o}, 8'h00);
        idle();
        io_rx_valid_i = 1'b1;
        io_rx_data_i  = 8'hEE;
        bus_set(1'b1, 1'b0, 32'h30000, 8'h00);
        #1;
        check("rx_full_pop_ready", {7'b0, io_rx_ready_o}, 8'h01);
        tick();
        io_rx_valid_i = 1'b0;
        check("rx_full_pop_byte", ram_data_o, 8'h80);
        bus_set(1'b1, 1'b0, 32'h0, 8'h00);
        #1;
        check("rx_still_full", {7'b0, io_rx_ready_o}, 8'h00);
        tick();
        for (int i = 1; i < 16; i++) begin
            bus_op(1'b1, 1'b0, 32'h30000, 8'h00);
            idle();
        end
        bus_op(1'b1, 1'b0, 32'h30000, 8'h00);
        check("rx_last_ee", ram_data_o, 8'hEE);
        idle();

        // rdy = 0: RAM write blocked and output held.
        bus_op(1'b1, 1'b0, 32'h00010, 8'h00);
        bus_op(1'b0, 1'b1, 32'h00010, 8'h99);
        check("rdy0_hold", ram_data_o, 8'hA5);
        bus_op(1'b1, 1'b0, 32'h00010, 8'h00);
        check("rdy0_no_write", ram_data_o, 8'hA5);

        // Reset between a TX write and its OK cycle.
        bus_op(1'b1, 1'b1, 32'h30000, 8'h55);
        check("pre_rst_tx_valid", {7'b0, io_tx_valid_o}, 8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("post_rst_tx_empty", {7'b0, io_tx_valid_o}, 8'h00);

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            rdy           = ($urandom_range(0, 9) != 0);
            io_tx_ready_i = ($urandom_range(0, 2) == 0);
            io_rx_valid_i = ($urandom_range(0, 2) == 0);
            d             = 8'($urandom);
            io_rx_data_i  = d;
            rst           = ($urandom_range(0, 399) == 0);
            if (n == 0 || $urandom_range(0, 4) != 0) begin
                k = $urandom_range(0, 9);
                a = $urandom;
                if (k <= 2) begin
                    a[16]   = 1'($urandom_range(0, 1));
                    a[15:0] = 16'($urandom_range(0, 31));
                    if (a[16]) a[17] = 1'b0;
                    ram_rw_i = 1'($urandom_range(0, 1));
                end else begin
                    a[17:16] = 2'b11;
                    if (k <= 5)      a[2:0] = 3'd0;
                    else if (k <= 7) a[2:0] = 3'd4;
                    else             a[2:0] = 3'($urandom_range(0, 7));
                    ram_rw_i = (k == 6) ? 1'b0 : 1'($urandom_range(0, 1));
                end
                ram_addr_i = a;
                d          = 8'($urandom);
                ram_data_i = d;
            end
            tick();
        end
        rst = 1'b0;
        bus_set(1'b0, 1'b0, 32'h0, 8'h00);
        io_rx_valid_i = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
